// File: rtl/cpu_muldiv_seq_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the iterative multiply/divide sequencer:
// ALU control encodings, RV32M/RV64M funct3 op codes, sequencer states
// and small op-classification helpers.
package cpu_muldiv_seq_pkg;

  // cpu_alu control encodings used by the sequencer
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_XOR = 4'd4;

  // funct3 values of the M-extension instructions
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NEG_A,
    ST_NEG_B,
    ST_STEP,
    ST_FIX_LO,
    ST_FIX_HI,
    ST_DONE
  } muldiv_state_e;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic isDivide(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic aIsSigned(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic bIsSigned(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic isRem(input muldiv_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // MUL, DIV and DIVU deliver the low accumulator half
  function automatic logic resultFromLo(input muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/cpu_muldiv_seq.sv
`timescale 1ns/1ps
// Iterative multiply/divide sequencer. It owns no wide arithmetic: every
// add/subtract is borrowed from the shared cpu_alu through the alu_* ports,
// one operation per cycle, with a fixed XLEN+5 cycle latency.
module cpu_muldiv_seq
  import cpu_muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] alu_operand_a,
  output logic [XLEN-1:0] alu_operand_b,
  output logic [3:0]      alu_control,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_unsigned_less_than
);

  localparam int CntW = $clog2(XLEN) + 1;

  muldiv_state_e   state_q,  state_d;
  muldiv_op_e      op_q,     op_d;
  logic [XLEN-1:0] a_q,      a_d;
  logic [XLEN-1:0] b_q,      b_d;
  logic [XLEN-1:0] hi_q,     hi_d;
  logic [XLEN-1:0] lo_q,     lo_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CntW-1:0] cnt_q,    cnt_d;
  logic            signA_q,  signA_d;
  logic            negRes_q, negRes_d;
  logic            loZero_q, loZero_d;

  logic            negA;
  logic            negB;
  logic            bZero;
  logic            divOp;
  logic [XLEN-1:0] shifted;
  logic            ge;
  logic            carry;

  // Operand conditioning flags and the per-step divide/multiply helpers
  assign divOp   = isDivide(op_q);
  assign negA    = aIsSigned(op_q) & a_q[XLEN-1];
  assign negB    = bIsSigned(op_q) & b_q[XLEN-1];
  assign bZero   = (b_q == '0);
  assign shifted = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
  assign ge      = hi_q[XLEN-1] | ~alu_unsigned_less_than;
  assign carry   = (alu_result < hi_q);

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      signA_q  <= 1'b0;
      negRes_q <= 1'b0;
      loZero_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      signA_q  <= signA_d;
      negRes_q <= negRes_d;
      loZero_q <= loZero_d;
    end
  end

  // ALU request for the current state; depends on registers only
  always_comb begin
    alu_operand_a = '0;
    alu_operand_b = '0;
    alu_control   = ALU_ADD;
    case (state_q)
      ST_NEG_A: begin
        alu_control   = negA ? ALU_SUB : ALU_ADD;
        alu_operand_a = negA ? '0 : a_q;
        alu_operand_b = negA ? a_q : '0;
      end
      ST_NEG_B: begin
        alu_control   = negB ? ALU_SUB : ALU_ADD;
        alu_operand_a = negB ? '0 : b_q;
        alu_operand_b = negB ? b_q : '0;
      end
      ST_STEP: begin
        if (divOp) begin
          alu_control   = ALU_SUB;
          alu_operand_a = shifted;
          alu_operand_b = b_q;
        end else begin
          alu_control   = ALU_ADD;
          alu_operand_a = hi_q;
          alu_operand_b = lo_q[0] ? a_q : '0;
        end
      end
      ST_FIX_LO: begin
        alu_control   = negRes_q ? ALU_SUB : ALU_ADD;
        alu_operand_a = negRes_q ? '0 : lo_q;
        alu_operand_b = negRes_q ? lo_q : '0;
      end
      ST_FIX_HI: begin
        if (negRes_q && !divOp) begin
          // High half of a two's-complement negation: ~hi plus the borrow
          // that only propagates when the low half was zero.
          alu_control   = ALU_ADD;
          alu_operand_a = ~hi_q;
          alu_operand_b = {{(XLEN-1){1'b0}}, loZero_q};
        end else if (negRes_q) begin
          alu_control   = ALU_SUB;
          alu_operand_a = '0;
          alu_operand_b = hi_q;
        end else begin
          alu_control   = ALU_ADD;
          alu_operand_a = hi_q;
          alu_operand_b = '0;
        end
      end
      default: begin
        alu_control   = ALU_ADD;
        alu_operand_a = '0;
        alu_operand_b = '0;
      end
    endcase
  end

  // Next-state and register updates, consuming the ALU result
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    signA_d  = signA_q;
    negRes_d = negRes_q;
    loZero_d = loZero_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !kill) begin
          op_d     = muldiv_op_e'(op);
          a_d      = rs1;
          b_d      = rs2;
          hi_d     = '0;
          lo_d     = '0;
          cnt_d    = '0;
          signA_d  = 1'b0;
          negRes_d = 1'b0;
          loZero_d = 1'b0;
          state_d  = ST_NEG_A;
        end
      end
      ST_NEG_A: begin
        a_d     = alu_result;
        signA_d = negA;
        state_d = ST_NEG_B;
      end
      ST_NEG_B: begin
        b_d   = alu_result;
        hi_d  = '0;
        cnt_d = '0;
        if (divOp) begin
          lo_d = a_q;
          // A zero divisor already yields -1 / dividend naturally, so the
          // quotient sign fixup is dropped; the remainder keeps A's sign.
          if (isRem(op_q)) negRes_d = signA_q;
          else             negRes_d = (signA_q ^ negB) & ~bZero;
        end else begin
          lo_d     = alu_result;
          negRes_d = signA_q ^ negB;
        end
        state_d = ST_STEP;
      end
      ST_STEP: begin
        if (divOp) begin
          hi_d = ge ? alu_result : shifted;
          lo_d = {lo_q[XLEN-2:0], ge};
        end else begin
          hi_d = {carry, alu_result[XLEN-1:1]};
          lo_d = {alu_result[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == CntW'(XLEN-1)) begin
          state_d = ST_FIX_LO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FIX_LO: begin
        loZero_d = (lo_q == '0);
        lo_d     = alu_result;
        state_d  = ST_FIX_HI;
      end
      ST_FIX_HI: begin
        hi_d     = alu_result;
        result_d = resultFromLo(op_q) ? lo_q : alu_result;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A flush abandons the operation without publishing a result
    if (kill && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end
  end

endmodule

// File: tb/tb_cpu_muldiv_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for cpu_muldiv_seq with a behavioural stand-in for cpu_alu.
module tb_cpu_muldiv_seq;
  import cpu_muldiv_seq_pkg::*;

  localparam int XLEN = 32;
  localparam int NV   = 19;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            kill;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] aluA;
  logic [XLEN-1:0] aluB;
  logic [3:0]      aluCtl;
  logic [XLEN-1:0] aluRes;
  logic            aluUlt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [XLEN-1:0] exp;
    int              dueCyc;
    string           name;
  } sbEntry_t;

  sbEntry_t sb[$];
  sbEntry_t ent;

  logic [2:0]      vOp  [NV] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110, 3'b101, 3'b111,
                                 3'b100, 3'b110, 3'b101, 3'b100, 3'b110,
                                 3'b001, 3'b001, 3'b011, 3'b000, 3'b100, 3'b110};
  logic [XLEN-1:0] vA   [NV] = '{32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd20, 32'd20,
                                 32'd5, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                                 32'h7FFF_FFFF, 32'h0000_0002, 32'h0001_0000, 32'h8000_0000,
                                 32'd20, 32'd20};
  logic [XLEN-1:0] vB   [NV] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'd3, 32'd3, 32'd3, 32'd3,
                                 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'h7FFF_FFFF, 32'hFFFF_FFFD, 32'h0001_0000, 32'h0000_0002,
                                 32'hFFFF_FFFD, 32'hFFFF_FFFD};
  logic [XLEN-1:0] vExp [NV] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                                 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd6, 32'd2,
                                 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,
                                 32'h3FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000,
                                 32'hFFFF_FFFA, 32'd2};
  string           vName[NV] = '{"MUL 7*-3", "MULH min*min", "MULHSU -1*max", "MULHU max*max",
                                 "DIV -20/3", "REM -20/3", "DIVU 20/3", "REMU 20/3",
                                 "DIV 5/0", "REM 5/0", "DIVU max/0", "DIV ovf", "REM ovf",
                                 "MULH maxpos^2", "MULH 2*-3", "MULHU 2^16*2^16", "MUL min*2",
                                 "DIV 20/-3", "REM 20/-3"};

  cpu_muldiv_seq #(.XLEN(XLEN)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .op                     (op),
    .rs1                    (rs1),
    .rs2                    (rs2),
    .kill                   (kill),
    .busy                   (busy),
    .done                   (done),
    .result                 (result),
    .alu_operand_a          (aluA),
    .alu_operand_b          (aluB),
    .alu_control            (aluCtl),
    .alu_result             (aluRes),
    .alu_unsigned_less_than (aluUlt)
  );

  // Clock generation
  always #5 clk = ~clk;

  // Cycle counter used for latency checks
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural cpu_alu: ADD, SUB, XOR and the unsigned less-than flag
  always_comb begin
    aluRes = aluA + aluB;
    case (aluCtl)
      4'd1:    aluRes = aluA - aluB;
      4'd4:    aluRes = aluA ^ aluB;
      default: aluRes = aluA + aluB;
    endcase
  end
  assign aluUlt = (aluA < aluB);

  task automatic checkOutput(input string name, input logic [XLEN-1:0] act,
                             input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Called on a negedge; the request is taken on the following posedge
  task automatic applyStimulus(input logic [2:0] o, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp,
                               input string name, input bit push);
    sbEntry_t e;
    start = 1'b1;
    op    = o;
    rs1   = a;
    rs2   = b;
    @(posedge clk);
    #1;
    if (push) begin
      e.exp    = exp;
      e.dueCyc = cyc + XLEN + 4;
      e.name   = name;
      sb.push_back(e);
    end
    start = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever done is presented
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected done", XLEN'(done), '0);
      end else begin
        ent = sb.pop_front();
        checkOutput({ent.name, " result"}, result, ent.exp);
        checkOutput({ent.name, " latency"}, XLEN'(cyc), XLEN'(ent.dueCyc));
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus
  initial begin
    reset = 1'b1;
    start = 1'b0;
    kill  = 1'b0;
    op    = '0;
    rs1   = '0;
    rs2   = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy",   XLEN'(busy), '0);
    checkOutput("reset done",   XLEN'(done), '0);
    checkOutput("reset result", result,      '0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vOp[i], vA[i], vB[i], vExp[i], vName[i], 1'b1);
      @(negedge clk);
      checkOutput({vName[i], " busy cycle 1"}, XLEN'(busy), XLEN'(1));
      repeat (XLEN + 4) @(negedge clk);
      checkOutput({vName[i], " busy cycle 37"}, XLEN'(busy), XLEN'(1));
      @(negedge clk);
      checkOutput({vName[i], " busy after done"}, XLEN'(busy), '0);
    end

    // Flush during STEP counter 10, then restart in the idle cycle
    applyStimulus(3'b100, 32'd100, 32'd7, '0, "killed DIV", 1'b0);
    repeat (13) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    checkOutput("kill busy", XLEN'(busy), '0);
    applyStimulus(3'b011, 32'h0001_0000, 32'h0001_0000, 32'h1, "MULHU after kill", 1'b1);
    repeat (XLEN + 6) @(negedge clk);
    checkOutput("after kill idle", XLEN'(busy), '0);

    // start together with kill in IDLE is not accepted
    start = 1'b1;
    kill  = 1'b1;
    op    = 3'b000;
    rs1   = 32'd9;
    rs2   = 32'd9;
    @(negedge clk);
    start = 1'b0;
    kill  = 1'b0;
    checkOutput("start+kill ignored", XLEN'(busy), '0);

    // A second start while busy is ignored
    applyStimulus(3'b101, 32'd1000, 32'd7, 32'd142, "DIVU 1000/7", 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    op    = 3'b000;
    rs1   = 32'd3;
    rs2   = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (33) @(negedge clk);
    checkOutput("busy start ignored", XLEN'(busy), '0);

    // Reset mid-operation clears everything and suppresses done
    applyStimulus(3'b111, 32'd100, 32'd7, '0, "reset REMU", 1'b0);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid reset busy",   XLEN'(busy), '0);
    checkOutput("mid reset done",   XLEN'(done), '0);
    checkOutput("mid reset result", result,      '0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(3'b111, 32'd100, 32'd7, 32'd2, "REMU 100/7", 1'b1);
    repeat (XLEN + 6) @(negedge clk);
    checkOutput("final idle", XLEN'(busy), '0);
    checkOutput("scoreboard drained", XLEN'(sb.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_muldiv_seq.md
Name: cpu_muldiv_seq

Overview:
Iterative RV32M/RV64M multiply/divide sequencer. It implements MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU by steering the existing shared cpu_alu through ADD/SUB/XOR steps. It holds no wide multiplier or divider of its own. It sits beside the execute stage, and the execute stage stalls on busy.

Parameters:
XLEN, 32, datapath width (32 or 64)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  request; accepted only in IDLE
op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  in  XLEN  operand A (multiplicand/dividend)
rs2  in  XLEN  operand B (multiplier/divisor)
kill  in  1  abort the current operation (pipeline flush)
busy  out  1  high from the cycle after acceptance through the DONE cycle
done  out  1  one-cycle pulse; result valid only while done=1
result  out  XLEN  final value, held until the next acceptance
alu_operand_a  out  XLEN  drives cpu_alu operand_a
alu_operand_b  out  XLEN  drives cpu_alu operand_b
alu_control  out  4  drives cpu_alu control (ADD=0, SUB=1, XOR=4 only)
alu_result  in  XLEN  cpu_alu result (combinational, same cycle)
alu_unsigned_less_than  in  1  cpu_alu unsigned_less_than flag

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset: state=IDLE; busy=0, done=0, result=0. All internal registers are cleared.
- ALU outputs are combinational from the state. In IDLE and DONE, alu_control=ADD and both operands=0.
- State sequence: IDLE -> NEG_A -> NEG_B -> STEP (XLEN cycles, counter 0..XLEN-1) -> FIX_LO -> FIX_HI -> DONE -> IDLE. There is no bypass, so latency is fixed.
- Acceptance: start=1 in IDLE samples op, rs1 and rs2. start is ignored in any other state.
- Latency: done=1 exactly XLEN+5 cycles after the accepting edge (37 for XLEN=32).
- Operand signedness: A is signed for MULH, MULHSU, DIV, REM. B is signed for MULH, DIV, REM.
- MUL uses the raw operands, with no sign fixup.
- NEG_A / NEG_B: if the operand is signed and negative, compute the absolute value with ALU SUB 0-x. Otherwise compute ALU ADD x+0.
- Record neg_res:
  - multiply: signA XOR signB.
  - DIV: signA XOR signB.
  - REM: signA.
- Multiply STEP, accumulator {hi, lo} with lo = |B| initially:
  - ALU ADD hi + (lo[0] ? |A| : 0).
  - carry = (alu_result < hi), using a local unsigned compare.
  - {hi, lo} <= {carry, alu_result, lo} >> 1.
- Divide STEP, hi = remainder (initially 0), lo = quotient/dividend (initially |A|):
  - shifted = {hi[XLEN-2:0], lo[XLEN-1]}.
  - ALU SUB shifted - |B|.
  - ge = hi[XLEN-1] | ~alu_unsigned_less_than.
  - hi <= ge ? alu_result : shifted.
  - lo <= {lo[XLEN-2:0], ge}.
- FIX_LO: if neg_res (and not MUL), lo <= 0 - lo via ALU SUB. Otherwise ADD lo+0.
  - Record lo_zero = (lo == 0) before negation.
- FIX_HI: if neg_res:
  - multiply: hi <= ~hi + lo_zero (ALU ADD with locally inverted operand).
  - divide/REM: hi <= 0 - hi.
  - Otherwise pass through.
- DONE result selection: MUL -> lo; MULH/MULHSU/MULHU -> hi; DIV/DIVU -> lo; REM/REMU -> hi.
- Divide by zero: the algorithm naturally yields quotient all-ones and remainder = dividend. The sign fixup is suppressed when B==0 (flag captured in NEG_B).
- Signed overflow (DIV of -2^(XLEN-1) by -1): the natural result is quotient = 0x80000000 and remainder 0, which is spec-correct. No special case is needed.
- kill: in any state except IDLE, the next state is IDLE, busy drops next cycle, and done is not asserted. kill in IDLE has no effect. kill together with start in IDLE: the request is not accepted.
- reset mid-operation: return to IDLE immediately. result is cleared and done is never pulsed.

Decomposition:
- Shared package cpu_pkg holds:
  - the ALU control encodings (currently the ALU_* defines, which become localparams);
  - the muldiv op enum (funct3 values);
  - the state enum typedef.
- No sub-module. The step counter is an inline $clog2(XLEN)+1-bit register.
- Top level instantiates one cpu_alu, muxed between the execute stage and this block by busy.

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFFFFFD) -> done at cycle 37, result=0xFFFFFFEB; busy high for cycles 1..37.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHSU -1*0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- DIV -20/3 -> 0xFFFFFFFA (-6); REM -20/3 -> 0xFFFFFFFE (-2); DIVU 20/3 -> 6; REMU 20/3 -> 2.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIVU 0xFFFFFFFF/0 -> 0xFFFFFFFF.
- Overflow: DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
- kill at STEP cycle 10 -> IDLE next cycle, no done. A new start in that IDLE cycle is accepted and its done arrives 37 cycles later. start while busy is ignored. reset at cycle 20 -> busy=0, result=0.
